// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------
// mem_arb_pkg : shared widths, state and port encodings
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W_DFLT = 28;
  localparam int LINE_W_DFLT = 128;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Port select doubles as the bit index into the two-bit request vector.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------
// arb_rr2 : two-input round-robin grant with one-bit pointer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       valid_o,
  output logic       gnt_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    valid_o = |req_i;
    if (req_i[PORT_I] && req_i[PORT_D]) begin
      gnt_o = ptr_q;
    end else if (req_i[PORT_D]) begin
      gnt_o = PORT_D;
    end else begin
      gnt_o = PORT_I;
    end
    ptr_d = ptr_q;
    // Preference moves to whichever port lost (or did not compete for) this grant.
    if (en_i && valid_o) begin
      ptr_d = ~gnt_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PORT_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------
// mem_arbiter : I/D cache line requests arbitrated onto one slow memory
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int LINE_W = LINE_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  logic [1:0]        state_q, state_d;
  logic              served_q;
  logic              after_resp_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_ready_q, d_ready_q;

  logic [1:0]        req, blocked, req_masked;
  logic              gnt_valid, gnt_port;
  logic              sel_d, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  assign req[PORT_I] = i_read | i_write;
  assign req[PORT_D] = d_read | d_write;

  // The requester only drops its line in the cycle after ready, so its stale
  // request is ignored for the first IDLE cycle following RESP.
  assign blocked    = after_resp_q ? ((served_q == PORT_D) ? 2'b10 : 2'b01) : 2'b00;
  assign req_masked = req & ~blocked;

  arb_rr2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_masked),
    .en_i    (state_q == IDLE),
    .valid_o (gnt_valid),
    .gnt_o   (gnt_port)
  );

  assign sel_d     = (gnt_port == PORT_D);
  assign sel_wr    = sel_d ? d_write : i_write;
  assign sel_addr  = sel_d ? d_addr  : i_addr;
  assign sel_wdata = sel_d ? d_wdata : i_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = BUSY;
      BUSY:    if (mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      served_q     <= PORT_D;
      after_resp_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      after_resp_q <= (state_q == RESP);
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      if ((state_q == IDLE) && gnt_valid) begin
        served_q    <= gnt_port;
        mem_read_q  <= ~sel_wr;
        mem_write_q <= sel_wr;
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      // Returned line lands straight in the served port's rdata register.
      if ((state_q == BUSY) && mem_ready) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        if (served_q == PORT_D) begin
          d_ready_q <= 1'b1;
          if (!mem_write_q) d_rdata_q <= mem_rdata;
        end else begin
          i_ready_q <= 1'b1;
          if (!mem_write_q) i_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------
// tb_mem_arbiter : directed vectors against a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [LW-1:0] i_wdata = '0, d_wdata = '0;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Slow memory: ready in the LAT-th cycle of a held request.
  int mem_lat = 4;
  int mem_cnt = 0;

  function automatic logic [LW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 28'h10) return {16{8'hA5}};
    return {4{4'hC, a}};
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    if (mem_read || mem_write) begin
      mem_cnt++;
      mem_ready = (mem_cnt == mem_lat);
      mem_rdata = mem_ready ? mem_data(mem_addr) : {4{32'hDEADBEEF}};
    end else begin
      mem_cnt   = 0;
      mem_ready = 1'b0;
      mem_rdata = {4{32'hDEADBEEF}};
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: ports numbered 0 = I, 1 = D.
  bit            m_valid = 1'b0;
  bit            m_on = 1'b0, m_resp = 1'b0, m_wr = 1'b0;
  int            m_port = 0, m_pref = 1, m_block = -1;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  logic [LW-1:0] m_rd [2];

  function automatic bit want(input int p);
    if (p == m_block) return 1'b0;
    return (p == 1) ? (d_read || d_write) : (i_read || i_write);
  endfunction

  function automatic int winner();
    if (want(0) && want(1)) return m_pref;
    return want(1) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_on <= 1'b0; m_resp <= 1'b0; m_wr <= 1'b0;
      m_pref <= 1; m_block <= -1;
      m_addr <= '0; m_wdata <= '0;
      m_rd[0] <= '0; m_rd[1] <= '0;
    end else if (m_resp) begin
      m_resp  <= 1'b0;
      m_block <= m_port;
    end else if (m_on) begin
      if (mem_ready) begin
        m_on   <= 1'b0;
        m_resp <= 1'b1;
        if (!m_wr) m_rd[m_port] <= mem_rdata;
      end
    end else begin
      m_block <= -1;
      if (want(0) || want(1)) begin
        m_on    <= 1'b1;
        m_port  <= winner();
        m_pref  <= 1 - winner();
        m_wr    <= (winner() == 1) ? d_write : i_write;
        m_addr  <= (winner() == 1) ? d_addr  : i_addr;
        m_wdata <= (winner() == 1) ? d_wdata : i_wdata;
      end
    end
  end

  // Monitor statistics used by the directed checks.
  int            n_rd_cyc = 0, n_wr_cyc = 0, n_i_rdy = 0, n_d_rdy = 0;
  int            i_rdy_cyc = 0, m_rdy_cyc = 0;
  logic [AW-1:0] log_addr [$];
  logic [LW-1:0] log_wdata [$];
  bit            log_wr [$];
  int            rise_cyc [$];
  bit            prev_mr = 1'b0;

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("mem_ctl", {126'd0, mem_read, mem_write}, {126'd0, m_on && !m_wr, m_on && m_wr});
      chk("mem_addr", {100'd0, mem_addr}, {100'd0, m_addr});
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("i_ready", {127'd0, i_ready}, {127'd0, m_resp && (m_port == 0)});
      chk("d_ready", {127'd0, d_ready}, {127'd0, m_resp && (m_port == 1)});
      chk("i_rdata", i_rdata, m_rd[0]);
      chk("d_rdata", d_rdata, m_rd[1]);
    end
    if (mem_read)  n_rd_cyc++;
    if (mem_write) n_wr_cyc++;
    if (i_ready) begin n_i_rdy++; i_rdy_cyc = cyc; end
    if (d_ready) n_d_rdy++;
    if ((mem_read || mem_write) && !prev_mr) rise_cyc.push_back(cyc);
    prev_mr = mem_read || mem_write;
    if (mem_ready && (mem_read || mem_write)) begin
      log_addr.push_back(mem_addr);
      log_wdata.push_back(mem_wdata);
      log_wr.push_back(mem_write);
      m_rdy_cyc = cyc;
    end
  end

  task automatic clear_stats();
    n_rd_cyc = 0; n_wr_cyc = 0; n_i_rdy = 0; n_d_rdy = 0;
    log_addr.delete(); log_wdata.delete(); log_wr.delete(); rise_cyc.delete();
  endtask

  task automatic wait_rdy(input int p);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!((p == 1) ? d_ready : i_ready) && k < 60);
    chk_int($sformatf("ready_seen_port%0d", p), int'((p == 1) ? d_ready : i_ready), 1);
  endtask

  int rc1;
  int k;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_mem_addr", {100'd0, mem_addr}, '0);
    chk("reset_d_rdata", d_rdata, '0);
    chk("reset_ctl", {124'd0, mem_read, mem_write, i_ready, d_ready}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single I read, latency 4.
    clear_stats();
    mem_lat = 4;
    i_addr = 28'h0000010; i_read = 1'b1;
    wait_rdy(0);
    i_read = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("t1_rd_cycles", n_rd_cyc, 4);
    chk_int("t1_i_pulses", n_i_rdy, 1);
    chk_int("t1_rdy_latency", i_rdy_cyc - m_rdy_cyc, 1);
    chk("t1_i_rdata", i_rdata, {16{8'hA5}});

    // Simultaneous I read and D write straight after reset.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    clear_stats();
    mem_lat = 2;
    d_addr = 28'h200; d_wdata = 128'h5555; d_write = 1'b1;
    i_addr = 28'h300; i_read = 1'b1;
    wait_rdy(1); d_write = 1'b0;
    wait_rdy(0); i_read = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("t2_txns", log_addr.size(), 2);
    chk("t2_first_addr", {100'd0, log_addr[0]}, 128'h200);
    chk_int("t2_first_wr", int'(log_wr[0]), 1);
    chk("t2_second_addr", {100'd0, log_addr[1]}, 128'h300);
    clear_stats();
    i_addr = 28'h310; d_addr = 28'h210; i_read = 1'b1; d_read = 1'b1;
    wait_rdy(1); d_read = 1'b0;
    wait_rdy(0); i_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_ptr_prefers_d", {100'd0, log_addr[0]}, 128'h210);

    // Back-to-back D reads with d_read held high across the boundary.
    clear_stats();
    d_addr = 28'h400; d_read = 1'b1;
    wait_rdy(1);
    rc1 = cyc;
    d_addr = 28'h401;
    wait_rdy(1);
    d_read = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("t3_txns", log_addr.size(), 2);
    chk_int("t3_d_pulses", n_d_rdy, 2);
    chk("t3_second_addr", {100'd0, log_addr[1]}, 128'h401);
    // RESP, one blocked IDLE, the granting IDLE, then BUSY.
    chk_int("t3_gap", rise_cyc[1] - rc1, 3);

    // D write leaves d_rdata alone.
    clear_stats();
    mem_lat = 3;
    d_addr = 28'h00000FF; d_wdata = 128'h1234; d_write = 1'b1;
    wait_rdy(1);
    d_write = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("t4_wr_cycles", n_wr_cyc, 3);
    chk_int("t4_rd_cycles", n_rd_cyc, 0);
    chk("t4_addr", {100'd0, log_addr[0]}, 128'hFF);
    chk("t4_wdata", log_wdata[0], 128'h1234);
    chk_int("t4_d_pulses", n_d_rdy, 1);
    chk("t4_d_rdata_kept", d_rdata, mem_data(28'h401));

    // Reset in the second BUSY cycle aborts the read.
    clear_stats();
    mem_lat = 4;
    i_addr = 28'h20; i_read = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_read && k < 20);
    @(negedge clk);
    rst = 1'b1; i_read = 1'b0;
    @(negedge clk);
    chk_int("t5_mem_read_dropped", int'(mem_read), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk_int("t5_no_ready", n_i_rdy + n_d_rdy, 0);
    chk_int("t5_no_txn", log_addr.size(), 0);
    i_addr = 28'h30; i_read = 1'b1;
    wait_rdy(0);
    i_read = 1'b0;
    chk("t5_fresh_rdata", i_rdata, mem_data(28'h30));

    // Read and write together on I is a write.
    repeat (2) @(negedge clk);
    clear_stats();
    mem_lat = 2;
    i_addr = 28'h50; i_wdata = 128'hBEEF; i_read = 1'b1; i_write = 1'b1;
    wait_rdy(0);
    i_read = 1'b0; i_write = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("t6_rd_cycles", n_rd_cyc, 0);
    chk_int("t6_wr_cycles", n_wr_cyc, 2);
    chk("t6_wdata", log_wdata[0], 128'hBEEF);
    chk("t6_i_rdata_kept", i_rdata, mem_data(28'h30));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
